// File: rtl/sum_accumulator.sv
// Handshaked accumulator behind the 4-bit adder: sums COUNT accepted 5-bit values
// into an ACC_W-bit total with a sticky overflow flag, then holds the result until taken.
module sum_accumulator #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [4:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned T_W   = ACC_W + 1;
  localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  logic [T_W-1:0]   w_t;
  logic             w_ovf_next;
  logic             w_in_hs;
  logic             w_out_hs;

  // One extra bit on the add catches the carry out of the accumulator.
  assign w_t        = T_W'(r_acc) + T_W'(in_sum);
  assign w_ovf_next = r_ovf | w_t[ACC_W];
  assign w_in_hs    = in_valid & r_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr && (r_state != S_INIT)) begin
      // Abort outranks any handshake in the same cycle.
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state    <= S_ACC;
          r_in_ready <= 1'b1;
        end
        S_ACC: begin
          if (w_in_hs) begin
            r_acc <= w_t[ACC_W-1:0];
            r_ovf <= w_ovf_next;
            if (r_cnt == CNT_LAST) begin
              r_out_sum   <= w_t[ACC_W-1:0];
              r_out_ovf   <= w_ovf_next;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          // Result registers keep their value after delivery.
          if (w_out_hs) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACC;
          end
        end
        default: begin
          r_state     <= S_INIT;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed scenarios plus a randomized run against a
// group-total reference model, on an 8-bit and a 6-bit instance sharing the inputs.
module tb_sum_accumulator;

  localparam int unsigned COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [4:0] in_sum;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic [7:0] out_sum_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [5:0] out_sum_b;

  sum_accumulator #(.COUNT(COUNT), .ACC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a)
  );

  sum_accumulator #(.COUNT(COUNT), .ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tracks the running group total as a plain integer.
  bit         m_live;
  int         m_n;
  int         m_tot;
  logic       e_in_ready, e_out_valid;
  logic [7:0] e_sum_a;
  logic       e_ovf_a;
  logic [5:0] e_sum_b;
  logic       e_ovf_b;

  task automatic model_reset();
    m_live = 0; m_n = 0; m_tot = 0;
    e_in_ready = 1'b0; e_out_valid = 1'b0;
    e_sum_a = '0; e_ovf_a = 1'b0; e_sum_b = '0; e_ovf_b = 1'b0;
  endtask

  task automatic model_edge(input logic iv, input logic [4:0] s, input logic ordy, input logic c);
    if (!m_live) begin
      m_live = 1; e_in_ready = 1'b1;
    end else if (c) begin
      m_n = 0; m_tot = 0; e_out_valid = 1'b0; e_in_ready = 1'b1;
    end else if (e_in_ready && iv) begin
      m_tot += int'(s);
      m_n++;
      if (m_n == int'(COUNT)) begin
        e_sum_a = 8'(m_tot); e_ovf_a = (m_tot > 255);
        e_sum_b = 6'(m_tot); e_ovf_b = (m_tot > 63);
        e_out_valid = 1'b1; e_in_ready = 1'b0;
      end
    end else if (e_out_valid && ordy) begin
      m_n = 0; m_tot = 0; e_out_valid = 1'b0; e_in_ready = 1'b1;
    end
  endtask

  task automatic step(input logic iv, input logic [4:0] s, input logic ordy, input logic c);
    in_valid = iv; in_sum = s; out_ready = ordy; clr = c;
    @(posedge clk);
    model_edge(iv, s, ordy, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready_a !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid_a); end
    n_checks++; if (out_sum_a !== 8'd0) begin n_errors++; $display("FAIL rst_out_sum got=%0d want=0", out_sum_a); end
    n_checks++; if (out_ovf_a !== 1'b0) begin n_errors++; $display("FAIL rst_out_ovf got=%b want=0", out_ovf_a); end
    rst_n = 1'b1;
    step(1'b1, 5'd9, 1'b0, 1'b0);
    n_checks++; if (in_ready_a !== 1'b1) begin n_errors++; $display("FAIL init_in_ready got=%b want=1", in_ready_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL init_out_valid got=%b want=0", out_valid_a); end
  endtask

  task automatic test_basic();
    logic [4:0] v [4] = '{5'd5, 5'd10, 5'd15, 5'd30};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v[i], 1'b1, 1'b0);
      if (i < 3) begin
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid i=%0d got=%b want=0", i, out_valid_a); end
      end
    end
    n_checks++; if (out_valid_a !== 1'b1) begin n_errors++; $display("FAIL basic_valid got=%b want=1", out_valid_a); end
    n_checks++; if (in_ready_a !== 1'b0) begin n_errors++; $display("FAIL basic_in_ready got=%b want=0", in_ready_a); end
    n_checks++; if (out_sum_a !== 8'd60) begin n_errors++; $display("FAIL basic_sum got=%0d want=60", out_sum_a); end
    n_checks++; if (out_ovf_a !== 1'b0) begin n_errors++; $display("FAIL basic_ovf got=%b want=0", out_ovf_a); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL basic_valid_drop got=%b want=0", out_valid_a); end
    n_checks++; if (in_ready_a !== 1'b1) begin n_errors++; $display("FAIL basic_ready_back got=%b want=1", in_ready_a); end
    n_checks++; if (out_sum_a !== 8'd60) begin n_errors++; $display("FAIL basic_sum_held got=%0d want=60", out_sum_a); end
  endtask

  task automatic test_backpressure();
    logic [4:0] v [4] = '{5'd5, 5'd10, 5'd15, 5'd30};
    for (int i = 0; i < 4; i++) step(1'b1, v[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'd7, 1'b0, 1'b0);
      n_checks++; if (out_sum_a !== 8'd60 || out_valid_a !== 1'b1) begin n_errors++; $display("FAIL bp_hold i=%0d got sum=%0d valid=%b want sum=60 valid=1", i, out_sum_a, out_valid_a); end
      n_checks++; if (in_ready_a !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready i=%0d got=%b want=0", i, in_ready_a); end
    end
    step(1'b1, 5'd7, 1'b1, 1'b0);
    n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_errors++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", in_ready_a, out_valid_a); end
    step(1'b1, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd1, 1'b0, 1'b0);
    n_checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 8'd10) begin n_errors++; $display("FAIL bp_next_group got sum=%0d valid=%b want sum=10 valid=1", out_sum_a, out_valid_a); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [4:0] v [4] = '{5'd31, 5'd31, 5'd2, 5'd0};
    for (int i = 0; i < 4; i++) step(1'b1, v[i], 1'b0, 1'b0);
    n_checks++; if (out_sum_b !== 6'd0 || out_ovf_b !== 1'b1) begin n_errors++; $display("FAIL ovf6_wrap got sum=%0d ovf=%b want sum=0 ovf=1", out_sum_b, out_ovf_b); end
    n_checks++; if (out_sum_a !== 8'd64 || out_ovf_a !== 1'b0) begin n_errors++; $display("FAIL ovf8_nowrap got sum=%0d ovf=%b want sum=64 ovf=0", out_sum_a, out_ovf_a); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 1'b0, 1'b0);
    n_checks++; if (out_sum_b !== 6'd4 || out_ovf_b !== 1'b0) begin n_errors++; $display("FAIL ovf6_cleared got sum=%0d ovf=%b want sum=4 ovf=0", out_sum_b, out_ovf_b); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    logic       vl [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] sv [7] = '{5'd3, 5'd0, 5'd0, 5'd4, 5'd0, 5'd5, 5'd6};
    for (int i = 0; i < 7; i++) begin
      step(vl[i], vl[i] ? sv[i] : 5'($urandom_range(31, 0)), 1'b0, 1'b0);
      if (i == 5) begin
        n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL gap_early_valid got=%b want=0", out_valid_a); end
      end
    end
    n_checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 8'd18) begin n_errors++; $display("FAIL gap_sum got sum=%0d valid=%b want sum=18 valid=1", out_sum_a, out_valid_a); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_clr();
    step(1'b1, 5'd9, 1'b0, 1'b0);
    step(1'b1, 5'd9, 1'b0, 1'b0);
    step(1'b1, 5'd9, 1'b0, 1'b1);
    n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_errors++; $display("FAIL clr_acc got ready=%b valid=%b want ready=1 valid=0", in_ready_a, out_valid_a); end
    for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 1'b0, 1'b0);
    n_checks++; if (out_valid_a !== 1'b1 || out_sum_a !== 8'd4) begin n_errors++; $display("FAIL clr_regroup got sum=%0d valid=%b want sum=4 valid=1", out_sum_a, out_valid_a); end
    step(1'b1, 5'd9, 1'b1, 1'b1);
    n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_errors++; $display("FAIL clr_done got valid=%b ready=%b want valid=0 ready=1", out_valid_a, in_ready_a); end
    step(1'b0, 5'd0, 1'b0, 1'b0);
    n_checks++; if (out_valid_a !== 1'b0) begin n_errors++; $display("FAIL clr_no_result got=%b want=0", out_valid_a); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] v [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    step(1'b1, 5'd20, 1'b0, 1'b0);
    step(1'b1, 5'd20, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin n_errors++; $display("FAIL amid_flags got ready=%b valid=%b want 0 0", in_ready_a, out_valid_a); end
    n_checks++; if (out_sum_a !== 8'd0 || out_ovf_a !== 1'b0) begin n_errors++; $display("FAIL amid_data got sum=%0d ovf=%b want 0 0", out_sum_a, out_ovf_a); end
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 5'd0, 1'b0, 1'b0);
    n_checks++; if (in_ready_a !== 1'b1) begin n_errors++; $display("FAIL amid_release got=%b want=1", in_ready_a); end
    for (int i = 0; i < 4; i++) step(1'b1, v[i], 1'b0, 1'b0);
    n_checks++; if (out_sum_a !== 8'd10) begin n_errors++; $display("FAIL amid_fresh got=%0d want=10", out_sum_a); end
    step(1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(99, 0) < 70), 5'($urandom_range(31, 0)),
           1'($urandom_range(99, 0) < 60), 1'($urandom_range(99, 0) < 4));
      n_checks++;
      if (in_ready_a !== e_in_ready || out_valid_a !== e_out_valid || out_sum_a !== e_sum_a || out_ovf_a !== e_ovf_a) begin
        n_errors++;
        $display("FAIL rand_a cyc=%0d got r=%b v=%b s=%0d o=%b want r=%b v=%b s=%0d o=%b", i,
                 in_ready_a, out_valid_a, out_sum_a, out_ovf_a, e_in_ready, e_out_valid, e_sum_a, e_ovf_a);
      end
      n_checks++;
      if (in_ready_b !== e_in_ready || out_valid_b !== e_out_valid || out_sum_b !== e_sum_b || out_ovf_b !== e_ovf_b) begin
        n_errors++;
        $display("FAIL rand_b cyc=%0d got r=%b v=%b s=%0d o=%b want r=%b v=%b s=%0d o=%b", i,
                 in_ready_b, out_valid_b, out_sum_b, out_ovf_b, e_in_ready, e_out_valid, e_sum_b, e_ovf_b);
      end
      n_checks++;
      if (in_ready_a && out_valid_a) begin
        n_errors++;
        $display("FAIL rand_exclusive cyc=%0d got ready=1 valid=1 want not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_gapped();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
